// File: rtl/seq_alu_pkg.sv
// Shared types for the sequential ALU: opcodes, FSM states and an opcode
// classifier.
package seq_alu_pkg;

    typedef enum logic [2:0] {
        ALU_ADD  = 3'b000,
        ALU_SUB  = 3'b001,
        ALU_AND  = 3'b010,
        ALU_OR   = 3'b011,
        ALU_SLT  = 3'b100,
        ALU_MUL  = 3'b101,
        ALU_DIVU = 3'b110,
        ALU_REMU = 3'b111
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        DONE
    } alu_state_e;

    function automatic logic is_multicycle(alu_op_e op);
        return op inside {ALU_MUL, ALU_DIVU, ALU_REMU};
    endfunction

endpackage

// File: rtl/seq_alu_muldiv.sv
// Iterative engine for MUL (shift-add) and DIVU/REMU (restoring division).
// Needs WIDTH steps; done is high during the last step, and result is that step's output.
module seq_alu_muldiv
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  alu_op_e          op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             done,
    output logic [WIDTH-1:0] result
);

    localparam int CNT_W = $clog2(WIDTH) + 1;

    alu_op_e          op_q;
    logic [WIDTH-1:0] acc_q, rem_q, a_q, b_q;
    logic [CNT_W-1:0] cnt_q;

    logic [WIDTH-1:0] acc_next, rem_next, a_next, b_next;
    logic [WIDTH:0]   shifted, trial;

    // NOTE: every always_comb output gets a default first, so no path can leave a latch behind.
    always_comb begin
        acc_next = acc_q;
        rem_next = rem_q;
        a_next   = a_q;
        b_next   = b_q;
        shifted  = {rem_q, acc_q[WIDTH-1]};
        trial    = shifted - {1'b0, b_q};
        if (op_q == ALU_MUL) begin
            acc_next = acc_q + (b_q[0] ? a_q : '0);
            a_next   = a_q << 1;
            b_next   = b_q >> 1;
        end else if (!trial[WIDTH]) begin
            // Divisor fits: keep the subtraction and shift in a quotient 1.
            // A zero divisor always fits, which yields all-ones / dividend.
            rem_next = trial[WIDTH-1:0];
            acc_next = {acc_q[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            acc_next = {acc_q[WIDTH-2:0], 1'b0};
        end
    end

    assign done   = (cnt_q == CNT_W'(1));
    assign result = (op_q == ALU_REMU) ? rem_next : acc_next;

    // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_q  <= ALU_MUL;
            acc_q <= '0;
            rem_q <= '0;
            a_q   <= '0;
            b_q   <= '0;
            cnt_q <= '0;
        end else if (start) begin
            op_q  <= op;
            acc_q <= (op == ALU_MUL) ? '0 : a;
            rem_q <= '0;
            a_q   <= a;
            b_q   <= b;
            cnt_q <= CNT_W'(WIDTH);
        end else if (cnt_q != '0) begin
            acc_q <= acc_next;
            rem_q <= rem_next;
            a_q   <= a_next;
            b_q   <= b_next;
            cnt_q <= cnt_q - CNT_W'(1);
        end
    end

endmodule

// File: rtl/seq_alu.sv
// Handshaked sequential ALU: one-cycle basic ops, WIDTH-step MUL/DIVU/REMU.
// Optional Carry/Overflow/Negative outputs are enabled with SEQ_ALU_FLAGS_EN.
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] InA,
    input  logic [WIDTH-1:0] InB,
    input  logic [2:0]       ALUOp,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [WIDTH-1:0] Res,
    output logic             Zero,
    output logic             out_valid,
    input  logic             out_ready
`ifdef SEQ_ALU_FLAGS_EN
    ,
    output logic             Carry,
    output logic             Overflow,
    output logic             Negative
`endif
);

    alu_state_e       state;
    alu_op_e          op_in;
    logic             accept, md_start, md_done;
    logic [WIDTH-1:0] alu_res, md_result;

    assign op_in    = alu_op_e'(ALUOp);
    assign accept   = in_valid && in_ready;
    assign md_start = accept && is_multicycle(op_in);

    always_comb begin
        alu_res = '0;
        case (op_in)
            ALU_ADD: alu_res = InA + InB;
            ALU_SUB: alu_res = InA - InB;
            ALU_AND: alu_res = InA & InB;
            ALU_OR:  alu_res = InA | InB;
            ALU_SLT: alu_res = {{(WIDTH-1){1'b0}}, (InA < InB)};
            default: alu_res = '0;
        endcase
    end

    seq_alu_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (md_start),
        .op     (op_in),
        .a      (InA),
        .b      (InB),
        .done   (md_done),
        .result (md_result)
    );

    // in_ready is registered so it stays low through reset and rises one cycle after release.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= IDLE;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            Res       <= '0;
            Zero      <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    in_ready <= 1'b1;
                    if (accept) begin
                        in_ready <= 1'b0;
                        if (is_multicycle(op_in)) begin
                            state <= BUSY;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            Res       <= alu_res;
                            Zero      <= (alu_res == '0);
                        end
                    end
                end
                BUSY: begin
                    if (md_done) begin
                        state     <= DONE;
                        out_valid <= 1'b1;
                        Res       <= md_result;
                        Zero      <= (md_result == '0);
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef SEQ_ALU_FLAGS_EN
    logic [WIDTH:0] add_full;
    logic           carry_in, ovf_in;

    assign add_full = {1'b0, InA} + {1'b0, InB};

    always_comb begin
        carry_in = 1'b0;
        ovf_in   = 1'b0;
        if (op_in == ALU_ADD) begin
            carry_in = add_full[WIDTH];
            ovf_in   = (InA[WIDTH-1] == InB[WIDTH-1]) && (alu_res[WIDTH-1] != InA[WIDTH-1]);
        end else if (op_in == ALU_SUB) begin
            carry_in = (InA < InB);
            ovf_in   = (InA[WIDTH-1] != InB[WIDTH-1]) && (alu_res[WIDTH-1] != InA[WIDTH-1]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            {Carry, Overflow, Negative} <= 3'b000;
        end else if (state == IDLE && accept && !is_multicycle(op_in)) begin
            {Carry, Overflow, Negative} <= {carry_in, ovf_in, alu_res[WIDTH-1]};
        end else if (state == BUSY && md_done) begin
            {Carry, Overflow, Negative} <= {2'b00, md_result[WIDTH-1]};
        end
    end
`endif

endmodule

// File: tb/tb_seq_alu.sv
// Self-checking bench for seq_alu: directed corner cases, then free-running
// random traffic compared every cycle against a transaction-level model.
module tb_seq_alu;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic [W-1:0] InA = '0, InB = '0;
    logic [2:0]   ALUOp = '0;
    logic         in_valid = 1'b0, out_ready = 1'b0;
    logic         in_ready, out_valid, Zero;
    logic [W-1:0] Res;
`ifdef SEQ_ALU_FLAGS_EN
    logic         Carry, Overflow, Negative;
`endif

    always #5 clk = ~clk;

    seq_alu #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .InA       (InA),
        .InB       (InB),
        .ALUOp     (ALUOp),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Res       (Res),
        .Zero      (Zero),
        .out_valid (out_valid),
        .out_ready (out_ready)
`ifdef SEQ_ALU_FLAGS_EN
        ,
        .Carry     (Carry),
        .Overflow  (Overflow),
        .Negative  (Negative)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference results straight from the opcode definitions.
    function automatic logic [W-1:0] ref_res(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        case (op)
            3'd0: return a + b;
            3'd1: return a - b;
            3'd2: return a & b;
            3'd3: return a | b;
            3'd4: return (a < b) ? W'(1) : W'(0);
            3'd5: return a * b;
            3'd6: return (b == '0) ? '1 : a / b;
            default: return (b == '0) ? a : a % b;
        endcase
    endfunction

`ifdef SEQ_ALU_FLAGS_EN
    function automatic logic [2:0] ref_flags(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] r);
        longint          sa = $signed(a);
        longint          sb = $signed(b);
        longint          s  = 0;
        longint unsigned ua = a;
        longint unsigned ub = b;
        logic            c = 1'b0, v = 1'b0;
        if (op == 3'd0) begin
            c = (ua + ub) >= 64'h1_0000_0000;
            s = sa + sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end else if (op == 3'd1) begin
            c = (a < b);
            s = sa - sb;
            v = (s > 64'sd2147483647) || (s < -64'sd2147483648);
        end
        return {c, v, r[W-1]};
    endfunction
    logic [2:0] m_fl = '0, m_pfl = '0;
`endif

    // Transaction-level model: ready/valid bookkeeping plus a latency countdown.
    logic         m_rdy = 1'b0, m_ov = 1'b0;
    logic [W-1:0] m_res = '0, m_pend = '0;
    int           m_wait = 0;
    int           n_acc = 0;
    logic         chk_en = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            m_rdy  <= 1'b0;
            m_ov   <= 1'b0;
            m_res  <= '0;
            m_wait <= 0;
        end else if (m_ov) begin
            if (out_ready) begin
                m_ov  <= 1'b0;
                m_rdy <= 1'b1;
            end
        end else if (m_wait > 0) begin
            m_wait <= m_wait - 1;
            if (m_wait == 1) begin
                m_ov  <= 1'b1;
                m_res <= m_pend;
`ifdef SEQ_ALU_FLAGS_EN
                m_fl  <= m_pfl;
`endif
            end
        end else if (!m_rdy) begin
            m_rdy <= 1'b1;
        end else if (in_valid) begin
            m_rdy <= 1'b0;
            n_acc <= n_acc + 1;
            if (ALUOp >= 3'd5) begin
                m_wait <= W;
                m_pend <= ref_res(ALUOp, InA, InB);
`ifdef SEQ_ALU_FLAGS_EN
                m_pfl  <= ref_flags(ALUOp, InA, InB, ref_res(ALUOp, InA, InB));
`endif
            end else begin
                m_ov  <= 1'b1;
                m_res <= ref_res(ALUOp, InA, InB);
`ifdef SEQ_ALU_FLAGS_EN
                m_fl  <= ref_flags(ALUOp, InA, InB, ref_res(ALUOp, InA, InB));
`endif
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("in_ready", W'(in_ready), W'(m_rdy));
            check("out_valid", W'(out_valid), W'(m_ov));
            if (m_ov) begin
                check("res", Res, m_res);
                check("zero", W'(Zero), W'(m_res == '0));
`ifdef SEQ_ALU_FLAGS_EN
                check("flags", W'({Carry, Overflow, Negative}), W'(m_fl));
`endif
            end
        end
    end

    // Issue one op from a negedge and wait for its result; returns at the negedge where out_valid is seen.
    task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                          output logic [W-1:0] r, output logic z, output int lat, output int rdy_seen);
        int guard = 0;
        while (!in_ready && guard < 100) begin
            @(negedge clk);
            guard++;
        end
        check("accept_wait", W'(in_ready), W'(1));
        in_valid = 1'b1;
        ALUOp    = op;
        InA      = a;
        InB      = b;
        @(negedge clk);
        in_valid = 1'b0;
        InA      = $urandom;
        InB      = $urandom;
        ALUOp    = 3'($urandom_range(0, 7));
        lat      = 1;
        rdy_seen = 0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen++;
            @(negedge clk);
            lat++;
        end
        check("result_wait", W'(out_valid), W'(1));
        r = Res;
        z = Zero;
    endtask

    task automatic release_out();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 4))
            0: return W'($urandom_range(0, 15));
            1: return '1 - W'($urandom_range(0, 3));
            2: return W'(1) << $urandom_range(0, W-1);
            3: return '0;
            default: return W'($urandom);
        endcase
    endfunction

    initial begin
        logic [W-1:0] r;
        logic         z;
        int           lat, rs;

        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        chk_en = 1'b1;
        check("rst_res", Res, '0);
        check("rst_zero", W'(Zero), W'(1));
        check("rst_out_valid", W'(out_valid), W'(0));
        check("rst_in_ready", W'(in_ready), W'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("ready_after_rst", W'(in_ready), W'(1));

        run_op(3'd0, 32'hFFFF_FFFF, 32'd1, r, z, lat, rs);
        check("add_wrap", r, 32'h0);
        check("add_zero", W'(z), W'(1));
        check("add_latency", W'(lat), W'(1));
`ifdef SEQ_ALU_FLAGS_EN
        check("add_carry", W'(Carry), W'(1));
        check("add_ovf", W'(Overflow), W'(0));
`endif
        release_out();

        run_op(3'd4, 32'd3, 32'd7, r, z, lat, rs);
        check("slt_lt", r, 32'd1);
        release_out();
        run_op(3'd4, 32'h8000_0000, 32'd1, r, z, lat, rs);
        check("slt_unsigned", r, 32'd0);
        check("slt_zero", W'(z), W'(1));
        release_out();

        run_op(3'd5, 32'h0001_0003, 32'h0002_0005, r, z, lat, rs);
        check("mul", r, 32'h000B_000F);
        check("mul_latency", W'(lat), W'(33));
        check("mul_ready_low", W'(rs), W'(0));
        release_out();

        run_op(3'd6, 32'd100, 32'd7, r, z, lat, rs);
        check("divu", r, 32'd14);
        check("divu_latency", W'(lat), W'(33));
        release_out();
        run_op(3'd7, 32'd100, 32'd7, r, z, lat, rs);
        check("remu", r, 32'd2);
        release_out();
        run_op(3'd6, 32'd5, 32'd0, r, z, lat, rs);
        check("divu_by0", r, 32'hFFFF_FFFF);
        release_out();
        run_op(3'd7, 32'd5, 32'd0, r, z, lat, rs);
        check("remu_by0", r, 32'd5);
        release_out();

        // Stalled consumer: result must hold while new requests are ignored.
        run_op(3'd0, 32'd5, 32'd6, r, z, lat, rs);
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            ALUOp    = 3'($urandom_range(0, 7));
            InA      = $urandom;
            InB      = $urandom;
            @(negedge clk);
            check("stall_res", Res, 32'd11);
            check("stall_zero", W'(Zero), W'(0));
            check("stall_valid", W'(out_valid), W'(1));
            check("stall_ready", W'(in_ready), W'(0));
        end
        in_valid = 1'b0;
        release_out();
        check("post_stall_valid", W'(out_valid), W'(0));
        check("post_stall_ready", W'(in_ready), W'(1));

        // Reset in the middle of a multiply.
        in_valid = 1'b1;
        ALUOp    = 3'd5;
        InA      = 32'h1234_5678;
        InB      = 32'h9ABC_DEF1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (16) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("midrst_valid", W'(out_valid), W'(0));
        check("midrst_res", Res, '0);
        check("midrst_zero", W'(Zero), W'(1));
        check("midrst_ready", W'(in_ready), W'(0));
        rst_n = 1'b1;
        @(negedge clk);
        check("midrst_ready_after", W'(in_ready), W'(1));
        run_op(3'd0, 32'd2, 32'd2, r, z, lat, rs);
        check("add_after_rst", r, 32'd4);
        release_out();

        // Free-running random traffic; the model and compare process do the checking.
        for (int i = 0; i < 4000; i++) begin
            rst_n     = ($urandom_range(0, 499) != 0);
            in_valid  = ($urandom_range(0, 2) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            ALUOp     = 3'($urandom_range(0, 7));
            InA       = pick();
            InB       = pick();
            @(negedge clk);
        end
        rst_n     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (40) @(negedge clk);
        check("rand_activity", W'(n_acc > 40), W'(1));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
